// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared FSM encoding, instruction field ranges and FIFO entry type for the fetch unit
package inst_fetch_pkg;

    localparam int INST_W     = 32;
    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_W   = 7;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_W   = 3;
    localparam int FUNCT7_LSB = 25;
    localparam int FUNCT7_W   = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_fifo.sv
// fetch_fifo: two-entry in-order buffer of {pc, inst}; entry e0 is always the head
module fetch_fifo
    import inst_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t e0, e1;
    logic [1:0]   cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0  <= '0;
            e1  <= '0;
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            // a pop shifts the tail forward; with one entry the incoming word becomes the new head
            if (pop)
                e0 <= (cnt == 2'd2) ? e1 : din;
            else if (push && cnt == 2'd0)
                e0 <= din;
            if (push && (cnt == 2'd2 || (cnt == 2'd1 && !pop)))
                e1 <= din;
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head  = e0;
    assign count = cnt;

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: single-outstanding instruction fetch with 2-entry buffer and redirect handling.
// Optional FETCH_ALIGN_CHECK_EN adds a sticky fetch_misalign flag that halts fetch.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    output logic        irom_req,
    output logic [31:0] irom_addr,
    input  logic        irom_rvalid,
    input  logic [31:0] irom_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7
`ifdef FETCH_ALIGN_CHECK_EN
    , output logic      fetch_misalign
`endif
);

    fetch_state_e state, state_nx;
    logic [31:0]  pc, pc_nx, redir_target;
    logic         push, pop, halt;
    logic [1:0]   count;
    fetch_entry_t head;

`ifdef FETCH_ALIGN_CHECK_EN
    assign halt         = fetch_misalign;
    assign redir_target = redirect_pc;

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst)
            fetch_misalign <= 1'b0;
        else
            fetch_misalign <= fetch_misalign | (redirect_valid & (|redirect_pc[1:0]));
    end
`else
    logic unused_redirect_lsb;
    assign halt                = 1'b0;
    assign redir_target        = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];
`endif

    // reset gating keeps the request low while cpu_rst holds the FSM in IDLE
    assign irom_req   = !cpu_rst && state == IDLE && !redirect_valid && count != 2'd2 && !halt;
    assign irom_addr  = pc;
    assign inst_valid = count != 2'd0;
    assign pop        = inst_valid && inst_ready && !redirect_valid;
    assign push       = state == WAIT && irom_rvalid && !redirect_valid;
    assign pc_nx      = redirect_valid ? redir_target : push ? pc + 32'd4 : pc;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = irom_req ? WAIT : IDLE;
            WAIT:    state_nx = irom_rvalid ? IDLE : redirect_valid ? DROP : WAIT;
            DROP:    state_nx = irom_rvalid ? IDLE : DROP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
        end
    end

    fetch_fifo u_fifo (
        .clk   (cpu_clk),
        .rst   (cpu_rst),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .din   ('{pc: pc, inst: irom_rdata}),
        .head  (head),
        .count (count)
    );

    assign inst    = head.inst;
    assign inst_pc = head.pc;
    assign opcode  = head.inst[OPCODE_LSB +: OPCODE_W];
    assign funct3  = head.inst[FUNCT3_LSB +: FUNCT3_W];
    assign funct7  = head.inst[FUNCT7_LSB +: FUNCT7_W];

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed and randomized fetch scenarios checked against a queue-based reference model
module tb_inst_fetch;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst = 1'b1;
    logic        irom_req;
    logic [31:0] irom_addr;
    logic        irom_rvalid = 1'b0;
    logic [31:0] irom_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst, inst_pc;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetch_misalign;
`endif

    int vectors = 0;
    int miscompares = 0;

    int          lat = 1;
    int          irom_cnt = 0;
    logic [31:0] irom_pend = '0;

    logic [31:0] q[$];
    logic [31:0] next_pc = RPC;
    bit          outst = 0, tainted = 0, halt = 0, saw_req = 0;

    inst_fetch #(.RESET_PC(RPC)) dut (
        .cpu_clk        (cpu_clk),
        .cpu_rst        (cpu_rst),
        .irom_req       (irom_req),
        .irom_addr      (irom_addr),
        .irom_rvalid    (irom_rvalid),
        .irom_rdata     (irom_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .opcode         (opcode),
        .funct3         (funct3),
        .funct7         (funct7)
`ifdef FETCH_ALIGN_CHECK_EN
        , .fetch_misalign (fetch_misalign)
`endif
    );

    initial forever #5 cpu_clk = ~cpu_clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(output bit exp_req);
        logic [31:0] w;
        exp_req = !cpu_rst && !outst && !redirect_valid && q.size() < 2 && !halt;
        chk("irom_req", 32'(irom_req), 32'(exp_req));
        if (exp_req) chk("irom_addr", irom_addr, next_pc);
        chk("inst_valid", 32'(inst_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            w = word_of(q[0]);
            chk("inst_pc", inst_pc, q[0]);
            chk("inst", inst, w);
            chk("opcode", 32'(opcode), 32'(w[6:0]));
            chk("funct3", 32'(funct3), 32'(w[14:12]));
            chk("funct7", 32'(funct7), 32'(w[31:25]));
        end
`ifdef FETCH_ALIGN_CHECK_EN
        chk("fetch_misalign", 32'(fetch_misalign), 32'(halt));
`endif
    endtask

    // one clock: drive inputs and the IROM model, check, then advance the reference model
    task automatic step(input bit rd, input logic [31:0] rpc, input bit rdy);
        bit exp_req;
        @(negedge cpu_clk);
        cpu_rst     = 1'b0;
        irom_rvalid = 1'b0;
        irom_rdata  = $urandom;
        if (irom_cnt > 0) begin
            irom_cnt--;
            if (irom_cnt == 0) begin
                irom_rvalid = 1'b1;
                irom_rdata  = word_of(irom_pend);
            end
        end
        redirect_valid = rd;
        redirect_pc    = rpc;
        inst_ready     = rdy;
        #1;
        check_outputs(exp_req);
        saw_req = irom_req;
        if (rd) begin
            q.delete();
`ifdef FETCH_ALIGN_CHECK_EN
            if (rpc[1:0] != 2'b00) halt = 1;
            next_pc = rpc;
`else
            next_pc = {rpc[31:2], 2'b00};
`endif
            if (outst) tainted = 1;
        end else begin
            if (q.size() != 0 && rdy) void'(q.pop_front());
            if (irom_rvalid && outst && !tainted) begin
                q.push_back(next_pc);
                next_pc += 32'd4;
            end
        end
        if (irom_rvalid) begin
            outst   = 0;
            tainted = 0;
        end
        if (exp_req) begin
            outst   = 1;
            tainted = 0;
        end
        if (irom_req) begin
            irom_cnt  = lat;
            irom_pend = irom_addr;
        end
    endtask

    task automatic apply_reset(input int n);
        @(negedge cpu_clk);
        cpu_rst        = 1'b1;
        redirect_valid = 1'b0;
        irom_rvalid    = 1'b0;
        inst_ready     = 1'b0;
        #1;
        chk("rst_irom_req", 32'(irom_req), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_fields", {15'd0, funct7, funct3, opcode}, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("rst_misalign", 32'(fetch_misalign), 32'd0);
`endif
        q.delete();
        next_pc  = RPC;
        outst    = 0;
        tainted  = 0;
        halt     = 0;
        irom_cnt = 0;
        repeat (n) @(posedge cpu_clk);
    endtask

    initial begin
        int k;
        logic [31:0] rpc;
        logic [31:0] addrs[$];
        apply_reset(3);
        // streaming fetch with one-cycle latency
        lat = 1;
        for (int i = 0; i < 12; i++) begin
            step(0, '0, 1);
            if (saw_req) addrs.push_back(irom_addr);
        end
        chk("stream_addr0", addrs[0], 32'h0);
        chk("stream_addr1", addrs[1], 32'h4);
        chk("stream_addr2", addrs[2], 32'h8);
        // back-pressure fills the buffer, then drains
        repeat (10) step(0, '0, 0);
        chk("bp_no_req", 32'(irom_req), 32'd0);
        repeat (6) step(0, '0, 1);
        // redirect one cycle after a slow request
        lat = 3;
        k = 0;
        do begin step(0, '0, 1); k++; end while (!saw_req && k < 20);
        chk("redir_req_seen", 32'(saw_req), 32'd1);
        step(1, 32'h100, 1);
        k = 0;
        do begin step(0, '0, 1); k++; end while (!saw_req && k < 20);
        chk("redir_next_addr", irom_addr, 32'h100);
        repeat (8) step(0, '0, 1);
        // redirect coinciding with a response while the buffer holds a word
        k = 0;
        do begin step(0, '0, 0); k++; end while (!(q.size() == 1 && irom_cnt == 1) && k < 30);
        chk("coincide_setup", q.size(), 32'd1);
        step(1, 32'h200, 1);
        step(0, '0, 1);
        chk("coincide_valid", 32'(inst_valid), 32'd0);
        chk("coincide_addr", irom_addr, 32'h200);
        repeat (8) step(0, '0, 1);
        // reset while a request is outstanding
        k = 0;
        do begin step(0, '0, 1); k++; end while (!saw_req && k < 20);
        step(0, '0, 1);
        apply_reset(2);
        lat = 1;
        step(0, '0, 1);
        chk("rst_restart_req", 32'(irom_req), 32'd1);
        chk("rst_restart_addr", irom_addr, RPC);
        repeat (8) step(0, '0, 1);
`ifdef FETCH_ALIGN_CHECK_EN
        step(1, 32'h102, 1);
        repeat (6) step(0, '0, 1);
        chk("misalign_set", 32'(fetch_misalign), 32'd1);
        chk("misalign_halt", 32'(irom_req), 32'd0);
        apply_reset(1);
`endif
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            lat = $urandom_range(1, 4);
            rpc = $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
            rpc[1:0] = ($urandom_range(0, 15) == 0) ? 2'b10 : 2'b00;
`endif
            if ($urandom_range(0, 199) == 0)
                apply_reset($urandom_range(1, 3));
            else
                step($urandom_range(0, 99) < 8, rpc, $urandom_range(0, 99) < 70);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
